// File: rtl/doorlock_pkg.sv
// doorlock_pkg: state encodings, key codes and key classification shared by the door lock
package doorlock_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction
endpackage

// File: rtl/dl_timer.sv
// dl_timer: loadable down-counter whose done flag is high while the count is zero
module dl_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign done = cnt == '0;
endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad password lock with timed unlock, entry timeout and failure lockout
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int                  PW_LEN        = 4,
    parameter logic [4*PW_LEN-1:0] PASSWORD      = 16'h1234,
    parameter int                  OPEN_CYCLES   = 5000,
    parameter int                  ENTRY_TIMEOUT = 5000,
    parameter int                  MAX_FAIL      = 3,
    parameter int                  LOCK_CYCLES   = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       ps_start,
    output logic       ps_end,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] state_out,
    output logic [1:0] fail_cnt
);
    localparam int BW = 4 * PW_LEN;
    localparam int CW = $clog2(PW_LEN + 1);
    localparam int T1 = OPEN_CYCLES > ENTRY_TIMEOUT ? OPEN_CYCLES : ENTRY_TIMEOUT;
    localparam int TMAX = T1 > LOCK_CYCLES ? T1 : LOCK_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [1:0] MF = 2'(MAX_FAIL);
    state_t state, nxt;
    logic [BW-1:0] digits;
    logic [CW-1:0] count;
    logic ovf, start_d, end_d, match, tmr_load, tmr_done;
    logic [1:0] fail_inc;
    logic [TW-1:0] tmr_val;
    assign match = count == CW'(PW_LEN) && !ovf && digits == PASSWORD;
    assign fail_inc = fail_cnt >= MF ? MF : fail_cnt + 2'd1;
    assign tmr_load = state != nxt || (state == ENTRY && key_valid);
    assign tmr_val = nxt == OPEN ? TW'(OPEN_CYCLES - 1) :
                     nxt == LOCKOUT ? TW'(LOCK_CYCLES - 1) : TW'(ENTRY_TIMEOUT - 1);
    dl_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(tmr_load),
        .load_val(tmr_val),
        .done(tmr_done)
    );
    always_comb begin
        nxt = state;
        start_d = 1'b0;
        end_d = 1'b0;
        case (state)
            IDLE: begin
                start_d = key_valid && key_code == KEY_STAR;
                nxt = start_d ? ENTRY : IDLE;
            end
            ENTRY: begin
                start_d = key_valid && key_code == KEY_STAR;
                end_d = key_valid && key_code == KEY_HASH;
                nxt = end_d ? CHECK : (!key_valid && tmr_done) ? IDLE : ENTRY;
            end
            CHECK:   nxt = match ? OPEN : FAIL;
            OPEN:    nxt = tmr_done ? IDLE : OPEN;
            FAIL:    nxt = fail_inc == MF ? LOCKOUT : IDLE;
            LOCKOUT: nxt = tmr_done ? IDLE : LOCKOUT;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ps_start <= 1'b0;
            ps_end <= 1'b0;
            digits <= '0;
            count <= '0;
            ovf <= 1'b0;
            fail_cnt <= '0;
        end else begin
            state <= nxt;
            ps_start <= start_d;
            ps_end <= end_d;
            if (start_d) begin
                digits <= '0;
                count <= '0;
                ovf <= 1'b0;
            end else if (state == ENTRY && key_valid && is_digit(key_code)) begin
                if (count < CW'(PW_LEN)) begin
                    digits <= (digits << 4) | BW'(key_code);
                    count <= count + CW'(1);
                end else begin
                    ovf <= 1'b1;
                end
            end
            if ((state == CHECK && match) || (state == LOCKOUT && tmr_done)) fail_cnt <= '0;
            else if (state == FAIL) fail_cnt <= fail_inc;
        end
    end
    assign unlock = state == OPEN;
    assign alarm = state == LOCKOUT;
    assign state_out = state;
endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl: directed scenario tests for the door lock controller
module tb_doorlock_ctrl;
    import doorlock_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic ps_start, ps_end, unlock, alarm;
    logic [2:0] state_out;
    logic [1:0] fail_cnt;
    int total = 0;
    int bad = 0;
    logic [3:0] seq [6] = '{KEY_STAR, 4'd1, 4'd2, 4'd3, 4'd4, KEY_HASH};
    doorlock_ctrl dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .ps_start(ps_start),
        .ps_end(ps_end),
        .unlock(unlock),
        .alarm(alarm),
        .state_out(state_out),
        .fail_cnt(fail_cnt)
    );
    always #5 clk = ~clk;
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        total++; if ({unlock, alarm, ps_start, ps_end} !== 4'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=0000", {unlock, alarm, ps_start, ps_end}); end
        total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
        rst = 1'b0;
    endtask
    task automatic test_unlock;
        int n;
        logic saw;
        press(KEY_STAR);
        total++; if (ps_start !== 1'b1 || ps_end !== 1'b0 || state_out !== 3'd1) begin bad++; $display("FAIL start_pulse got=%b%b st=%0d exp=10 st=1", ps_start, ps_end, state_out); end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        total++; if (ps_start !== 1'b0) begin bad++; $display("FAIL start_one_cycle got=%b exp=0", ps_start); end
        press(KEY_HASH);
        total++; if (ps_end !== 1'b1 || ps_start !== 1'b0 || state_out !== 3'd2) begin bad++; $display("FAIL end_pulse got=%b%b st=%0d exp=01 st=2", ps_start, ps_end, state_out); end
        key_valid = 1'b1;
        key_code = KEY_STAR;
        @(negedge clk);
        key_valid = 1'b0;
        total++; if (state_out !== 3'd3 || unlock !== 1'b1 || ps_start !== 1'b0 || ps_end !== 1'b0) begin bad++; $display("FAIL check_to_open st=%0d unlock=%b ps=%b%b exp st=3 unlock=1 ps=00", state_out, unlock, ps_start, ps_end); end
        n = 0;
        saw = 1'b0;
        while (unlock === 1'b1 && n < 6000) begin
            n++;
            saw |= ps_start;
            key_valid = n == 10;
            key_code = KEY_STAR;
            @(negedge clk);
        end
        key_valid = 1'b0;
        total++; if (n !== 5000) begin bad++; $display("FAIL open_cycles got=%0d exp=5000", n); end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL open_key_ignored got=%b exp=0", saw); end
        total++; if (state_out !== 3'd0) begin bad++; $display("FAIL open_to_idle got=%0d exp=0", state_out); end
    endtask
    task automatic test_fail;
        press(KEY_STAR); press(4'd1); press(4'd2); press(4'd3); press(KEY_HASH);
        total++; if (state_out !== 3'd2) begin bad++; $display("FAIL short_check got=%0d exp=2", state_out); end
        @(negedge clk);
        total++; if (state_out !== 3'd4 || unlock !== 1'b0) begin bad++; $display("FAIL short_fail st=%0d unlock=%b exp st=4 unlock=0", state_out, unlock); end
        key_valid = 1'b1;
        key_code = KEY_STAR;
        @(negedge clk);
        key_valid = 1'b0;
        total++; if (state_out !== 3'd0 || fail_cnt !== 2'd1 || ps_start !== 1'b0) begin bad++; $display("FAIL short_after st=%0d fc=%0d ps_start=%b exp st=0 fc=1 ps_start=0", state_out, fail_cnt, ps_start); end
        press(KEY_STAR); press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(KEY_HASH);
        @(negedge clk);
        total++; if (state_out !== 3'd4 || unlock !== 1'b0) begin bad++; $display("FAIL ovf_fail st=%0d unlock=%b exp st=4 unlock=0", state_out, unlock); end
        @(negedge clk);
        total++; if (state_out !== 3'd0 || fail_cnt !== 2'd2) begin bad++; $display("FAIL ovf_after st=%0d fc=%0d exp st=0 fc=2", state_out, fail_cnt); end
    endtask
    task automatic test_lockout;
        int n;
        logic saw;
        press(KEY_STAR); press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_HASH);
        repeat (2) @(negedge clk);
        total++; if (state_out !== 3'd5 || alarm !== 1'b1 || fail_cnt !== 2'd3) begin bad++; $display("FAIL lockout_enter st=%0d alarm=%b fc=%0d exp st=5 alarm=1 fc=3", state_out, alarm, fail_cnt); end
        n = 0;
        saw = 1'b0;
        while (alarm === 1'b1 && n < 21000) begin
            n++;
            saw |= ps_start;
            key_valid = n == 100 || n == 101;
            key_code = n == 100 ? KEY_STAR : 4'd1;
            @(negedge clk);
        end
        key_valid = 1'b0;
        total++; if (n !== 20000) begin bad++; $display("FAIL lock_cycles got=%0d exp=20000", n); end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL lock_key_ignored got=%b exp=0", saw); end
        total++; if (state_out !== 3'd0 || fail_cnt !== 2'd0) begin bad++; $display("FAIL lock_exit st=%0d fc=%0d exp st=0 fc=0", state_out, fail_cnt); end
    endtask
    task automatic test_timeout;
        int n;
        logic saw;
        press(KEY_STAR); press(KEY_HASH);
        repeat (2) @(negedge clk);
        total++; if (fail_cnt !== 2'd1) begin bad++; $display("FAIL empty_entry_fc got=%0d exp=1", fail_cnt); end
        press(KEY_STAR); press(4'd1); press(4'd2);
        n = 0;
        saw = 1'b0;
        while (state_out === 3'd1 && n < 6000) begin
            n++;
            saw |= ps_end;
            @(negedge clk);
        end
        total++; if (n !== 5000) begin bad++; $display("FAIL timeout_cycles got=%0d exp=5000", n); end
        total++; if (state_out !== 3'd0 || fail_cnt !== 2'd1 || saw !== 1'b0) begin bad++; $display("FAIL timeout_exit st=%0d fc=%0d ps_end=%b exp st=0 fc=1 ps_end=0", state_out, fail_cnt, saw); end
        press(KEY_STAR); press(4'd9); press(KEY_STAR);
        total++; if (ps_start !== 1'b1 || state_out !== 3'd1) begin bad++; $display("FAIL restart ps_start=%b st=%0d exp ps_start=1 st=1", ps_start, state_out); end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_HASH);
        @(negedge clk);
        total++; if (state_out !== 3'd3 || unlock !== 1'b1 || fail_cnt !== 2'd0) begin bad++; $display("FAIL restart_open st=%0d unlock=%b fc=%0d exp st=3 unlock=1 fc=0", state_out, unlock, fail_cnt); end
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (unlock !== 1'b0 || state_out !== 3'd0) begin bad++; $display("FAIL reset_mid_open unlock=%b st=%0d exp unlock=0 st=0", unlock, state_out); end
        rst = 1'b0;
    endtask
    task automatic test_back_to_back;
        press(4'd12);
        total++; if (state_out !== 3'd0 || ps_start !== 1'b0) begin bad++; $display("FAIL idle_ignore st=%0d ps_start=%b exp st=0 ps_start=0", state_out, ps_start); end
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_code = seq[i];
            @(negedge clk);
        end
        key_valid = 1'b0;
        total++; if (state_out !== 3'd2 || ps_end !== 1'b1 || ps_start !== 1'b0) begin bad++; $display("FAIL b2b_check st=%0d ps=%b%b exp st=2 ps=01", state_out, ps_start, ps_end); end
        @(negedge clk);
        total++; if (state_out !== 3'd3 || unlock !== 1'b1) begin bad++; $display("FAIL b2b_open st=%0d unlock=%b exp st=3 unlock=1", state_out, unlock); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({unlock, alarm, ps_start, ps_end} !== 4'b0 || state_out !== 3'd0) begin bad++; $display("FAIL b2b_reset outs=%b st=%0d exp outs=0000 st=0", {unlock, alarm, ps_start, ps_end}, state_out); end
        rst = 1'b0;
    endtask
    initial begin
        test_reset;
        test_unlock;
        test_fail;
        test_lockout;
        test_timeout;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
